ising_run_ctrl: RTL and testbench
=================================

# ising_run_ctrl

Run sequencer for the Ising machine. It loads the coupling weights into the core matrix through its write port, then performs `num_runs` anneal runs. Each run holds the oscillator array in reset, releases it, waits a programmed number of cycles and captures the sampled phase vector. Captured results go to the host over a valid/ready stream. The block sits between the host/AXI-side logic and `top_ising`, and owns `ising_rstn`, `axi_rstn`, the weight write strobe and the sampler limits.

## Interface
- `N`, 3: spin count; width of the phase vector.
- `RST_CYCLES`, 4: cycles `ising_rstn` is held low before each run (≥1).
- `IDX_W`, 16: width of the run counter and run index.

Ports:
- `clk` in 1: single clock for all logic.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a job; sampled only in IDLE.
- `num_runs` in IDX_W: runs per job; latched at `start`.
- `run_cycles` in 32: cycles `ising_rstn` stays high per run; latched at `start`; 0 is treated as 1.
- `cfg_counter_max`, `cfg_counter_cutoff` in 32: sampler limits; latched at `start`.
- `wt_valid` in 1, `wt_ready` out 1, `wt_addr` in 32, `wt_data` in 32, `wt_last` in 1: weight stream from the host.
- `res_valid` out 1, `res_ready` in 1, `res_phase` out N, `res_idx` out IDX_W: result stream.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse at job end.
- `ising_rstn` out 1, `axi_rstn` out 1, `wready` out 1, `wr_addr` out 32, `wdata` out 32: to the core.
- `counter_max`, `counter_cutoff` out 32: to the sampler.
- `phase` in N: from the sampler.

## Operation
- States: IDLE, LOAD, HOLD, RUN, CAPT, FIN.
- IDLE:
  - `wt_ready`=0, `ising_rstn`=0.
  - On `start`: latch the config, clear the run counter, go to LOAD.
- LOAD:
  - `wt_ready`=1.
  - Each `wt_valid&&wt_ready` beat drives `wready`=1 with `wr_addr`/`wdata` registered, one cycle after the beat.
  - A beat with `wt_last` ends LOAD. Next state is HOLD, or FIN if `num_runs`==0.
- HOLD:
  - `ising_rstn`=0 for exactly RST_CYCLES cycles, then go to RUN.
- RUN:
  - `ising_rstn`=1 for exactly `run_cycles` cycles, then go to CAPT.
- CAPT:
  - Register `phase` into `res_phase` on the first CAPT cycle. `ising_rstn` is already 0 from this cycle on.
  - Set `res_valid`=1 and `res_idx`=run counter.
  - Hold every value until `res_ready`.
  - On the handshake: increment the run counter. Go to HOLD if the counter < `num_runs`, else go to FIN.
- FIN:
  - Pulse `done` for one cycle, return to IDLE.
- `start` outside IDLE is ignored. Config changes outside IDLE have no effect.
- `axi_rstn` is the registered `~rst`, so it releases one cycle after `rst` falls.
- `counter_max`/`counter_cutoff` outputs are the latched values. They stay stable from LOAD through FIN.

## Timing
- Reset values: state IDLE. `ising_rstn`=0, `axi_rstn`=0, `wready`=0, `wr_addr`=`wdata`=0, `wt_ready`=0, `res_valid`=0, `res_phase`=0, `res_idx`=0, `busy`=0, `done`=0, `counter_*`=0.
- `rst` mid-job aborts immediately to the reset values. No result or `done` is emitted.
- `start`→LOAD: 1 cycle. `busy` rises the cycle after `start`.
- Weight latency: `wready` pulse one cycle after the accepted beat. One beat per cycle is sustained.
- A run takes RST_CYCLES + `run_cycles` + 1 + (cycles `res_ready` is low).
- Run counter increments only on the result handshake. At IDX_W all-ones, the final run is index 2^IDX_W−2 with no wrap, since the count is limited by `num_runs`.
- `wt_last` with `wt_valid` low is ignored.

## Configuration
- `ISING_RUN_STATS_EN`:
  - Defined:
    - Adds output `res_flips` (IDX_W): number of bits differing between this run's phase and the previous run's phase, 0 for run 0.
    - Adds output `job_cycles` (32): saturating count of `busy` cycles, valid at `done`.
  - Undefined: these ports and their counters are absent. All other behaviour is identical.

## Structure
- Shared package `ising_pkg` (or `defines.vh`):
  - the state encoding constants;
  - the defaults for RST_CYCLES and IDX_W.
- One sub-module: `popcount` (parameter W), used only under `ISING_RUN_STATS_EN` for `res_flips`.

## Test plan
- Reset then start with 3 weight beats (last on the 3rd), `num_runs`=2, `run_cycles`=10, RST_CYCLES=4 → 3 `wready` pulses with matching addr/data. `ising_rstn` low 4 cycles / high 10 cycles, twice. Results idx 0,1. `done` pulses once.
- `num_runs`=0 → LOAD completes, no `res_valid`, `done` one cycle after the last beat.
- Hold `res_ready` low 20 cycles in CAPT → `res_phase`/`res_idx` stable and `ising_rstn`=0 throughout. Next HOLD begins the cycle after acceptance.
- Assert `rst` during RUN → next cycle all outputs at reset values, and no `done` pulse.
- `start` pulsed during RUN with a new `num_runs` → ignored. The job finishes with its original count.
- `ISING_RUN_STATS_EN`, phases 3'b000 then 3'b101 → `res_flips` 0 then 2. `job_cycles` equals the measured `busy` length.

Source files
------------

// File: rtl/ising_pkg.sv
// Shared definitions for the Ising run sequencer: FSM state encoding and
// default timing/width parameters.
package ising_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_HOLD = 3'd2,
    S_RUN  = 3'd3,
    S_CAPT = 3'd4,
    S_FIN  = 3'd5
  } run_state_e;

  localparam int RST_CYCLES_DEF = 4;
  localparam int IDX_W_DEF      = 16;

endpackage

// File: rtl/popcount.sv
// Combinational population count of a W-bit vector; counts the phase bits
// that flipped between consecutive runs.
module popcount #(
  parameter int W     = 3,
  parameter int OUT_W = $clog2(W + 1)
) (
  input  logic [W-1:0]     bits_i,
  output logic [OUT_W-1:0] cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < W; i++) begin
      cnt_o = cnt_o + OUT_W'(bits_i[i]);
    end
  end

endmodule

// File: rtl/ising_run_ctrl.sv
// Run sequencer: loads weights into the core, then performs num_runs anneal
// runs and streams the captured phases out. Optional stats: ISING_RUN_STATS_EN.
//
// state  | meaning
// IDLE   | waiting for start, array held in reset
// LOAD   | accepting weight beats, forwarding them to the core write port
// HOLD   | ising_rstn low for RST_CYCLES cycles
// RUN    | ising_rstn high for run_cycles cycles
// CAPT   | phase captured, result offered until res_ready
// FIN    | one-cycle done pulse, back to IDLE
module ising_run_ctrl
  import ising_pkg::*;
#(
  parameter int N          = 3,
  parameter int RST_CYCLES = RST_CYCLES_DEF,
  parameter int IDX_W      = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W-1:0] num_runs,
  input  logic [31:0]      run_cycles,
  input  logic [31:0]      cfg_counter_max,
  input  logic [31:0]      cfg_counter_cutoff,
  input  logic             wt_valid,
  output logic             wt_ready,
  input  logic [31:0]      wt_addr,
  input  logic [31:0]      wt_data,
  input  logic             wt_last,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [N-1:0]     res_phase,
  output logic [IDX_W-1:0] res_idx,
  output logic             busy,
  output logic             done,
  output logic             ising_rstn,
  output logic             axi_rstn,
  output logic             wready,
  output logic [31:0]      wr_addr,
  output logic [31:0]      wdata,
  output logic [31:0]      counter_max,
  output logic [31:0]      counter_cutoff,
  input  logic [N-1:0]     phase
`ifdef ISING_RUN_STATS_EN
  ,
  output logic [IDX_W-1:0] res_flips,
  output logic [31:0]      job_cycles
`endif
);

  localparam logic [31:0]      HOLD_LOAD = 32'(RST_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  run_state_e       state_q;
  logic [31:0]      timer_q;
  logic [IDX_W-1:0] num_runs_q;
  logic [31:0]      run_cycles_q;
  logic [IDX_W-1:0] run_cnt_q;
  logic [IDX_W-1:0] run_cnt_d;
  logic             wt_ready_q, res_valid_q, busy_q, done_q;
  logic             ising_rstn_q, axi_rstn_q, wready_q;
  logic [31:0]      wr_addr_q, wdata_q, cmax_q, ccut_q;
  logic [N-1:0]     res_phase_q;
  logic [IDX_W-1:0] res_idx_q;

  // run_cnt_q never exceeds num_runs_q - 1, so the increment cannot wrap
  assign run_cnt_d = run_cnt_q + IDX_ONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      num_runs_q   <= '0;
      run_cycles_q <= '0;
      run_cnt_q    <= '0;
      wt_ready_q   <= 1'b0;
      res_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ising_rstn_q <= 1'b0;
      axi_rstn_q   <= 1'b0;
      wready_q     <= 1'b0;
      wr_addr_q    <= '0;
      wdata_q      <= '0;
      cmax_q       <= '0;
      ccut_q       <= '0;
      res_phase_q  <= '0;
      res_idx_q    <= '0;
    end else begin
      axi_rstn_q <= 1'b1;
      wready_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            num_runs_q   <= num_runs;
            run_cycles_q <= (run_cycles == 32'd0) ? 32'd1 : run_cycles;
            cmax_q       <= cfg_counter_max;
            ccut_q       <= cfg_counter_cutoff;
            run_cnt_q    <= '0;
            busy_q       <= 1'b1;
            wt_ready_q   <= 1'b1;
            state_q      <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (wt_valid) begin
            wready_q  <= 1'b1;
            wr_addr_q <= wt_addr;
            wdata_q   <= wt_data;
            if (wt_last) begin
              wt_ready_q <= 1'b0;
              if (num_runs_q == '0) begin
                done_q  <= 1'b1;
                state_q <= S_FIN;
              end else begin
                timer_q <= HOLD_LOAD;
                state_q <= S_HOLD;
              end
            end
          end
        end
        S_HOLD: begin
          if (timer_q == 32'd0) begin
            ising_rstn_q <= 1'b1;
            timer_q      <= run_cycles_q - 32'd1;
            state_q      <= S_RUN;
          end else begin
            timer_q <= timer_q - 32'd1;
          end
        end
        S_RUN: begin
          if (timer_q == 32'd0) begin
            ising_rstn_q <= 1'b0;
            res_valid_q  <= 1'b1;
            res_phase_q  <= phase;
            res_idx_q    <= run_cnt_q;
            state_q      <= S_CAPT;
          end else begin
            timer_q <= timer_q - 32'd1;
          end
        end
        S_CAPT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            run_cnt_q   <= run_cnt_d;
            if (run_cnt_d < num_runs_q) begin
              timer_q <= HOLD_LOAD;
              state_q <= S_HOLD;
            end else begin
              done_q  <= 1'b1;
              state_q <= S_FIN;
            end
          end
        end
        S_FIN: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wt_ready       = wt_ready_q;
  assign res_valid      = res_valid_q;
  assign res_phase      = res_phase_q;
  assign res_idx        = res_idx_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign ising_rstn     = ising_rstn_q;
  assign axi_rstn       = axi_rstn_q;
  assign wready         = wready_q;
  assign wr_addr        = wr_addr_q;
  assign wdata          = wdata_q;
  assign counter_max    = cmax_q;
  assign counter_cutoff = ccut_q;

`ifdef ISING_RUN_STATS_EN
  logic [N-1:0]     prev_phase_q;
  logic [IDX_W-1:0] flips_d;
  logic [IDX_W-1:0] res_flips_q;
  logic [31:0]      job_cycles_q;

  popcount #(.W(N), .OUT_W(IDX_W)) u_popcount (
    .bits_i (phase ^ prev_phase_q),
    .cnt_o  (flips_d)
  );

  // job_cycles includes the FIN cycle, so it equals the busy length at done
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_phase_q <= '0;
      res_flips_q  <= '0;
      job_cycles_q <= '0;
    end else begin
      if (state_q == S_IDLE && start) begin
        job_cycles_q <= 32'd1;
      end else if (busy_q && state_q != S_FIN && job_cycles_q != '1) begin
        job_cycles_q <= job_cycles_q + 32'd1;
      end
      if (state_q == S_RUN && timer_q == 32'd0) begin
        prev_phase_q <= phase;
        res_flips_q  <= (run_cnt_q == '0) ? '0 : flips_d;
      end
    end
  end

  assign res_flips  = res_flips_q;
  assign job_cycles = job_cycles_q;
`endif

endmodule

// File: tb/tb_ising_run_ctrl.sv
// Self-checking bench for ising_run_ctrl: table-driven jobs plus hand-written
// reset-abort sequence. Build with ISING_RUN_STATS_EN to check the stats ports.
module tb_ising_run_ctrl;

  localparam int N     = 3;
  localparam int IDX_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [IDX_W-1:0] num_runs;
  logic [31:0]      run_cycles, cfg_counter_max, cfg_counter_cutoff;
  logic             wt_valid, wt_ready, wt_last;
  logic [31:0]      wt_addr, wt_data;
  logic             res_valid, res_ready;
  logic [N-1:0]     res_phase;
  logic [IDX_W-1:0] res_idx;
  logic             busy, done, ising_rstn, axi_rstn, wready;
  logic [31:0]      wr_addr, wdata, counter_max, counter_cutoff;
  logic [N-1:0]     phase;
`ifdef ISING_RUN_STATS_EN
  logic [IDX_W-1:0] res_flips;
  logic [31:0]      job_cycles;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ising_run_ctrl #(.N(N), .RST_CYCLES(4), .IDX_W(IDX_W)) dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .num_runs           (num_runs),
    .run_cycles         (run_cycles),
    .cfg_counter_max    (cfg_counter_max),
    .cfg_counter_cutoff (cfg_counter_cutoff),
    .wt_valid           (wt_valid),
    .wt_ready           (wt_ready),
    .wt_addr            (wt_addr),
    .wt_data            (wt_data),
    .wt_last            (wt_last),
    .res_valid          (res_valid),
    .res_ready          (res_ready),
    .res_phase          (res_phase),
    .res_idx            (res_idx),
    .busy               (busy),
    .done               (done),
    .ising_rstn         (ising_rstn),
    .axi_rstn           (axi_rstn),
    .wready             (wready),
    .wr_addr            (wr_addr),
    .wdata              (wdata),
    .counter_max        (counter_max),
    .counter_cutoff     (counter_cutoff),
    .phase              (phase)
`ifdef ISING_RUN_STATS_EN
    ,
    .res_flips          (res_flips),
    .job_cycles         (job_cycles)
`endif
  );

  typedef struct packed {
    int              nr;        // num_runs
    int              rc;        // run_cycles input
    int              nb;        // weight beats
    int              rl;        // CAPT cycles with res_ready low
    int              exp_high;  // expected ising_rstn high length per run
    int              exp_busy;  // expected busy length of the whole job
    logic [2:0][2:0] ph;        // phase presented during run i
    logic [2:0][3:0] fl;        // expected res_flips for run i
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [2:0] ph_at(input vec_t v, input int i);
    int j;
    j = (i > 2) ? 2 : i;
    return v.ph[j];
  endfunction

  function automatic logic [3:0] fl_at(input vec_t v, input int i);
    int j;
    j = (i > 2) ? 2 : i;
    return v.fl[j];
  endfunction

  function automatic logic [31:0] beat_addr(input int b);
    return 32'(256 + 4 * b);
  endfunction

  function automatic logic [31:0] beat_data(input int b, input int nr);
    return 32'hC0DE_0000 ^ 32'(b * 17 + nr);
  endfunction

  task automatic reset_checks(input string tag);
    chk({tag, "_ising_rstn"}, ising_rstn, 0);
    chk({tag, "_axi_rstn"}, axi_rstn, 0);
    chk({tag, "_wready"}, wready, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wdata"}, wdata, 0);
    chk({tag, "_wt_ready"}, wt_ready, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_phase"}, res_phase, 0);
    chk({tag, "_res_idx"}, res_idx, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_counter_max"}, counter_max, 0);
    chk({tag, "_counter_cutoff"}, counter_cutoff, 0);
  endtask

  task automatic run_job(input vec_t v, input bit poke);
    int results, hold_len, high_len, capt_cnt, busy_obs, nseg, done_cnt;
    bit saw_done, poked;
    logic [31:0] cm, cc;
    cm = 32'hA000_0000 + 32'(v.rc);
    cc = 32'h0000_0B00 + 32'(v.nr);
    results = 0; hold_len = 0; high_len = 0; capt_cnt = 0;
    busy_obs = 0; nseg = 0; done_cnt = 0; saw_done = 0; poked = 0;

    @(negedge clk);
    start = 1'b1; num_runs = 16'(v.nr); run_cycles = 32'(v.rc);
    cfg_counter_max = cm; cfg_counter_cutoff = cc;
    @(negedge clk);
    start = 1'b0; num_runs = 16'd9; run_cycles = 32'd50;
    cfg_counter_max = 32'hFFFF_FFFF; cfg_counter_cutoff = 32'h1234_5678;
    chk("busy_rise", busy, 1);
    chk("wt_ready_load", wt_ready, 1);
    busy_obs++;
    wt_valid = 1'b0; wt_last = 1'b1;
    @(negedge clk);
    for (int b = 0; b < v.nb; b++) begin
      if (busy) busy_obs++;
      if (b == 0) begin
        chk("last_without_valid_wready", wready, 0);
        chk("last_without_valid_stays_load", wt_ready, 1);
      end else begin
        chk("beat_wready", wready, 1);
        chk("beat_wr_addr", wr_addr, beat_addr(b - 1));
        chk("beat_wdata", wdata, beat_data(b - 1, v.nr));
      end
      wt_valid = 1'b1; wt_addr = beat_addr(b); wt_data = beat_data(b, v.nr);
      wt_last = (b == v.nb - 1);
      @(negedge clk);
    end
    wt_valid = 1'b0; wt_last = 1'b0;
    chk("last_beat_wready", wready, 1);
    chk("last_beat_wr_addr", wr_addr, beat_addr(v.nb - 1));
    chk("last_beat_wdata", wdata, beat_data(v.nb - 1, v.nr));
    chk("wt_ready_after_last", wt_ready, 0);

    for (int cyc = 0; cyc < 3000 && !saw_done; cyc++) begin
      start = 1'b0;
      if (busy) busy_obs++;
      phase = ph_at(v, results);
      chk("counter_max_latched", counter_max, cm);
      chk("counter_cutoff_latched", counter_cutoff, cc);
      if (done) begin
        saw_done = 1;
        done_cnt++;
        res_ready = 1'b0;
        chk("results_at_done", results, v.nr);
        chk("runs_at_done", nseg, v.nr);
        chk("res_valid_at_done", res_valid, 0);
`ifdef ISING_RUN_STATS_EN
        chk("job_cycles", job_cycles, v.exp_busy);
`endif
      end else if (res_valid) begin
        if (high_len > 0) begin
          chk("run_high_len", high_len, v.exp_high);
          nseg++;
          high_len = 0;
        end
        capt_cnt++;
        chk("capt_ising_rstn_low", ising_rstn, 0);
        chk("res_idx", res_idx, results);
        chk("res_phase", res_phase, ph_at(v, results));
`ifdef ISING_RUN_STATS_EN
        chk("res_flips", res_flips, fl_at(v, results));
`endif
        if (capt_cnt > v.rl) begin
          res_ready = 1'b1;
          results++;
          capt_cnt = 0;
        end else begin
          res_ready = 1'b0;
        end
      end else begin
        res_ready = 1'b0;
        if (ising_rstn) begin
          if (hold_len > 0) begin
            chk("hold_low_len", hold_len, 4);
            hold_len = 0;
          end
          high_len++;
          if (poke && !poked) begin
            start = 1'b1; num_runs = 16'd7; run_cycles = 32'd3;
            poked = 1;
          end
        end else begin
          hold_len++;
        end
      end
      @(negedge clk);
    end
    res_ready = 1'b0;
    start = 1'b0;
    chk("job_done_seen", saw_done, 1);
    chk("busy_len", busy_obs, v.exp_busy);
    chk("busy_after_fin", busy, 0);
    repeat (3) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    chk("done_pulse_count", done_cnt, 1);
    chk("idle_ising_rstn", ising_rstn, 0);
  endtask

  initial begin
    int waited, seen;
    rst = 1'b1; start = 1'b0; num_runs = '0; run_cycles = '0;
    cfg_counter_max = '0; cfg_counter_cutoff = '0;
    wt_valid = 1'b0; wt_addr = '0; wt_data = '0; wt_last = 1'b0;
    res_ready = 1'b0; phase = '0;

    vecs[0] = '{nr: 2, rc: 10, nb: 3, rl: 0, exp_high: 10, exp_busy: 35,
                ph: {3'b000, 3'b101, 3'b000}, fl: {4'd0, 4'd2, 4'd0}};
    vecs[1] = '{nr: 0, rc: 10, nb: 2, rl: 0, exp_high: 10, exp_busy: 4,
                ph: {3'b000, 3'b000, 3'b000}, fl: {4'd0, 4'd0, 4'd0}};
    vecs[2] = '{nr: 1, rc: 0, nb: 1, rl: 20, exp_high: 1, exp_busy: 29,
                ph: {3'b000, 3'b000, 3'b110}, fl: {4'd0, 4'd0, 4'd0}};
    vecs[3] = '{nr: 3, rc: 2, nb: 1, rl: 1, exp_high: 2, exp_busy: 27,
                ph: {3'b100, 3'b010, 3'b011}, fl: {4'd2, 4'd1, 4'd0}};

    repeat (2) @(negedge clk);
    reset_checks("reset");
    rst = 1'b0;
    chk("axi_rstn_still_low", axi_rstn, 0);
    @(negedge clk);
    chk("axi_rstn_released", axi_rstn, 1);
    chk("idle_busy", busy, 0);

    for (int i = 0; i < 4; i++) begin
      run_job(vecs[i], i == 3);
    end

    // reset asserted mid-run aborts the job
    @(negedge clk);
    start = 1'b1; num_runs = 16'd2; run_cycles = 32'd10;
    cfg_counter_max = 32'h55; cfg_counter_cutoff = 32'h66;
    @(negedge clk);
    start = 1'b0; wt_valid = 1'b1; wt_last = 1'b1; wt_addr = 32'h44; wt_data = 32'h99;
    @(negedge clk);
    wt_valid = 1'b0; wt_last = 1'b0;
    waited = 0;
    while (!ising_rstn && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("abort_reached_run", ising_rstn, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    reset_checks("abort");
    rst = 1'b0;
    @(negedge clk);
    chk("abort_axi_rstn", axi_rstn, 1);
    seen = 0;
    repeat (40) begin
      if (done || res_valid || busy) seen++;
      @(negedge clk);
    end
    chk("abort_no_done_or_result", seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
